// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider, h/v counters and phase FSMs, registered sync/blank.
// Define VGA_FRAME_CNT_EN to build the completed-frame counter; otherwise frame_cnt reads 0.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic signed [10:0] hcount,
  output logic signed [10:0] vcount,
  output logic               blank,
  output logic               hsync,
  output logic               vsync,
  output logic               pix_tick,
  output logic               frame_start,
  output logic [15:0]        frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_FP_START  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYN_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_BP_START  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST      = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_FP_START  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYN_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_BP_START  = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [2:0]  DIV_LAST    = 3'(CLK_DIV - 1);

  typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYN, H_BACK} h_state_t;
  typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYN, V_BACK} v_state_t;

  logic [2:0]  div_cnt;
  logic [10:0] h_cnt, v_cnt;
  logic [10:0] h_next, v_next;
  logic        pix_en, h_wrap, v_wrap, frame_wrap;
  h_state_t    h_state, h_state_nxt;
  v_state_t    v_state, v_state_nxt;

  always_comb begin
    pix_en     = (div_cnt == DIV_LAST);
    h_wrap     = (h_cnt == H_LAST);
    v_wrap     = (v_cnt == V_LAST);
    frame_wrap = pix_en && h_wrap && v_wrap;
    h_next     = h_wrap ? 11'd0 : h_cnt + 11'd1;
    v_next     = v_wrap ? 11'd0 : v_cnt + 11'd1;
  end

  // Phase FSMs look at the counter values about to be loaded, so the registered
  // sync/blank outputs land on the same edge as the counters they describe.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
    h_state_nxt = h_state;
    v_state_nxt = v_state;
    if (pix_en) begin
      unique case (h_state)
        H_ACT:   if (h_next == H_FP_START)  h_state_nxt = H_FRONT;
        H_FRONT: if (h_next == H_SYN_START) h_state_nxt = H_SYN;
        H_SYN:   if (h_next == H_BP_START)  h_state_nxt = H_BACK;
        H_BACK:  if (h_next == 11'd0)       h_state_nxt = H_ACT;
      endcase
      if (h_wrap) begin
        unique case (v_state)
          V_ACT:   if (v_next == V_FP_START)  v_state_nxt = V_FRONT;
          V_FRONT: if (v_next == V_SYN_START) v_state_nxt = V_SYN;
          V_SYN:   if (v_next == V_BP_START)  v_state_nxt = V_BACK;
          V_BACK:  if (v_next == 11'd0)       v_state_nxt = V_ACT;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      h_state     <= H_ACT;
      v_state     <= V_ACT;
      blank       <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      pix_tick    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= pix_en ? 3'd0 : div_cnt + 3'd1;
      pix_tick    <= pix_en;
      frame_start <= frame_wrap;
      if (pix_en) begin
        h_cnt <= h_next;
        if (h_wrap) v_cnt <= v_next;
      end
      h_state <= h_state_nxt;
      v_state <= v_state_nxt;
      blank   <= !((h_state_nxt == H_ACT) && (v_state_nxt == V_ACT));
      hsync   <= (h_state_nxt != H_SYN);
      vsync   <= (v_state_nxt != V_SYN);
    end
  end

  assign hcount = h_cnt;
  assign vcount = v_cnt;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)          frame_cnt_q <= '0;
    else if (frame_wrap) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

endmodule
